// File: rtl/btn_debounce_pulse.sv
// Push-button synchronizer, debouncer and press/release strobe generator.
// Optional auto-repeat of the press strobe while held: define BTN_AUTOREPEAT_EN.
module btn_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        HELD_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
        (64'(1) << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES) ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_param
        $error("btn_debounce_pulse: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_d, press_d, release_d;
    logic                   rep_fire;
    logic                   cnt_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt_q == CNT_LAST);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DELAY - 1);
    // After a strobe, rewind so the next one lands REPEAT_PERIOD cycles later.
    localparam logic [REP_W-1:0] REP_REWIND = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rep_q, rep_d;

    assign rep_fire = (rep_q == REP_LAST);

    always_comb begin
        rep_d = rep_q;
        unique case (state_q)
            HELD_HIGH: begin
                if (s) begin
                    rep_d = rep_fire ? REP_REWIND : rep_q + REP_W'(1);
                end
            end
            WAIT_LOW: rep_d = rep_q;
            default:  rep_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = o_btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                level_d = 1'b0;
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HELD_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD_HIGH: begin
                level_d = 1'b1;
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    press_d = rep_fire;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d   = IDLE_LOW;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q         <= IDLE_LOW;
            cnt_q           <= '0;
            o_btn_level     <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            o_btn_level     <= level_d;
            o_press_pulse   <= press_d;
            o_release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: per-cycle vector table with a scoreboard queue,
// plus hand sequences for auto-repeat hold and press/release counting.
module tb_btn_debounce_pulse;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_WIDTH       = 3;
    localparam int REPEAT_DELAY    = 8;
    localparam int REPEAT_PERIOD   = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_btn;
    logic o_btn_level;
    logic o_press_pulse;
    logic o_release_pulse;

    btn_debounce_pulse #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_btn          (i_btn),
        .o_btn_level    (o_btn_level),
        .o_press_pulse  (o_press_pulse),
        .o_release_pulse(o_release_pulse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string tag;
        logic  rst;
        logic  btn;
        logic  lvl;
        logic  prs;
        logic  rel;
    } vec_t;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } sb_t;

    vec_t       tbl[$];
    sb_t        sbq[$];
    int         checks   = 0;
    int         failures = 0;
    bit         tally_en = 1'b0;
    int         press_cnt = 0;
    logic [2:0] led = 3'd0;

    function automatic void add(string tag, int n, logic rst, logic btn,
                                logic lvl, logic prs, logic rel);
        vec_t v;
        v.tag = tag;
        v.rst = rst;
        v.btn = btn;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic drive(string tag, logic rst, logic btn,
                         logic lvl, logic prs, logic rel);
        sb_t        e;
        sb_t        got;
        logic [2:0] act;
        i_reset = rst;
        i_btn   = btn;
        e.tag   = tag;
        e.exp   = {lvl, prs, rel};
        sbq.push_back(e);
        @(posedge i_clk);
        #1;
        act = {o_btn_level, o_press_pulse, o_release_pulse};
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow %s actual=%b required=entry", tag, act);
        end else begin
            got = sbq.pop_front();
            if (act !== got.exp) begin
                failures++;
                $display("FAIL %s lvl/prs/rel actual=%b required=%b",
                         got.tag, act, got.exp);
            end
        end
        if (tally_en && o_press_pulse === 1'b1) begin
            press_cnt++;
            led = led + 3'd1;
        end
    endtask

    initial begin
        int h;
        i_reset = 1'b1;
        i_btn   = 1'b0;

        add("reset", 3, 1, 0, 0, 0, 0);
        add("clean", 5, 0, 1, 0, 0, 0);
        add("clean", 1, 0, 1, 1, 1, 0);
        add("clean", 14, 0, 1, 1, 0, 0);
        for (int r = 0; r < 2; r++) begin
            add("relbnc", 2, 0, 0, 1, 0, 0);
            add("relbnc", 1, 0, 1, 1, 0, 0);
        end
        add("relbnc", 4, 0, 1, 1, 0, 0);
        add("release", 5, 0, 0, 1, 0, 0);
        add("release", 1, 0, 0, 0, 0, 1);
        add("release", 4, 0, 0, 0, 0, 0);
        for (int r = 0; r < 5; r++) begin
            add("bounce", 2, 0, 1, 0, 0, 0);
            add("bounce", 1, 0, 0, 0, 0, 0);
        end
        add("bounce", 6, 0, 0, 0, 0, 0);
        add("rstmid", 3, 0, 1, 0, 0, 0);
        add("rstmid", 2, 1, 1, 0, 0, 0);
        add("rstmid", 5, 0, 1, 0, 0, 0);
        add("rstmid", 1, 0, 1, 1, 1, 0);
        add("rstmid", 4, 0, 1, 1, 0, 0);
        add("rsthold", 2, 1, 0, 0, 0, 0);
        add("rsthold", 6, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].rst, tbl[i].btn,
                  tbl[i].lvl, tbl[i].prs, tbl[i].rel);
        end

        // Hold for H raw cycles: FSM sees the high level on edges 2..H+1.
        h = 23;
        for (int e = 0; e < h + 10; e++) begin
            drive($sformatf("hold[%0d]", e), 1'b0, e < h,
                  (e >= 5) && (e < h + 5),
                  (e == 5) || (AR && e >= 13 && e <= h + 1 && (e - 13) % 3 == 0),
                  e == h + 5);
        end

        tally_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int j = 0; j < 8; j++) begin
                drive($sformatf("pair%0d_hi[%0d]", p, j), 1'b0, 1'b1,
                      j >= 5, j == 5, 1'b0);
            end
            for (int j = 0; j < 8; j++) begin
                drive($sformatf("pair%0d_lo[%0d]", p, j), 1'b0, 1'b0,
                      j < 5, 1'b0, j == 5);
            end
        end
        tally_en = 1'b0;

        checks++;
        if (press_cnt != 20) begin
            failures++;
            $display("FAIL press_count actual=%0d required=20", press_cnt);
        end
        checks++;
        if (led != 3'd4) begin
            failures++;
            $display("FAIL led_count actual=%0d required=4", led);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Conditions a raw mechanical push-button into clean, clock-synchronous events for the LED counter datapath.
- Synchronizes the asynchronous pin into the i_clk domain.
- Rejects bounce and glitches shorter than a programmable window.
- Emits a debounced level, plus single-cycle press and release strobes.
- Sits between the board button pin and the counter's increment input, so the counter advances exactly once per physical press.

Parameters:
SYNC_STAGES, 2, flip-flops in the input synchronizer chain (legal range 2..4)
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz; must be >= 2)
CNT_WIDTH, 20, width of the debounce counter (must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES)
REPEAT_DELAY, 50000000, cycles held before auto-repeat starts (used only with the optional feature)
REPEAT_PERIOD, 10000000, cycles between auto-repeat strobes (used only with the optional feature)

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_btn  input  1  raw asynchronous button pin, active-high
o_btn_level  output  1  debounced button level
o_press_pulse  output  1  one-cycle strobe on accepted press (and on auto-repeat, if enabled)
o_release_pulse  output  1  one-cycle strobe on accepted release

Behaviour:
- Reset:
  - Clock is i_clk; reset is i_reset, synchronous and active-high.
  - While i_reset=1 at a clock edge: synchronizer chain <= 0, FSM <= IDLE_LOW, counters <= 0, all outputs <= 0.
  - Reset takes priority over every other event.
  - A reset asserted mid-debounce or mid-hold aborts the operation with no strobe emitted.
  - A button still held when reset deasserts is treated as a fresh press and re-debounced.
- Synchronizer: i_btn passes through SYNC_STAGES flops; the last stage is the sample s. The FSM uses only s.
- FSM states:
  - IDLE_LOW: level=0. If s=1: go to WAIT_HIGH, cnt <= 1.
  - WAIT_HIGH: level=0.
    - If s=0: return to IDLE_LOW, cnt <= 0. The glitch is rejected and no strobe is emitted.
    - If s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD_HIGH, o_btn_level <= 1, o_press_pulse <= 1, cnt <= 0.
    - Otherwise cnt <= cnt+1.
  - HELD_HIGH: level=1. If s=0: go to WAIT_LOW, cnt <= 1.
  - WAIT_LOW: level=1.
    - If s=1: return to HELD_HIGH, cnt <= 0.
    - If s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE_LOW, o_btn_level <= 0, o_release_pulse <= 1.
    - Otherwise cnt <= cnt+1.
- Latency:
  - Raw i_btn stable high from before edge 0: o_btn_level and o_press_pulse rise after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Release is symmetric.
- Strobes:
  - All outputs are registered.
  - Each strobe is high for exactly one cycle.
  - o_press_pulse and o_release_pulse are never high in the same cycle.
  - Bounce inside either window restarts the count from 1 on the next stable sample and produces no strobe.
- Counter never wraps; it saturates logically at DEBOUNCE_CYCLES-1 because a state transition always occurs there.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined:
  - A separate repeat counter runs in HELD_HIGH only, starting at 0 on entry.
  - When it reaches REPEAT_DELAY-1, o_press_pulse fires for one cycle.
  - Thereafter o_press_pulse fires every REPEAT_PERIOD cycles while the FSM remains in HELD_HIGH.
  - Entering WAIT_LOW freezes the repeat counter.
  - Returning to HELD_HIGH from WAIT_LOW resumes the repeat counter without a new press strobe.
  - Reaching IDLE_LOW clears the repeat counter.
- Undefined: no repeat counter is instantiated; exactly one o_press_pulse per accepted press.

Test Plan:
(Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.)
1. Clean press: i_btn 0->1 before edge 0, held 20 cycles -> o_btn_level and o_press_pulse go 1 after edge 5; pulse drops after edge 6; level stays 1.
2. Bounce rejection: i_btn high for 2 cycles, low 1 cycle, repeated 5 times, then low -> no strobe, o_btn_level stays 0 throughout.
3. Release: from held state, i_btn 1->0 stable -> o_btn_level 0 and o_release_pulse 1 for one cycle, after 5 edges; exactly one release per press.
4. Reset mid-debounce: i_btn high, i_reset=1 at edge 3 for 2 cycles, button still held -> all outputs 0 during reset; press strobe appears 6 edges after reset deasserts.
5. Counter integration: 20 clean press/release pairs into top_counter increment -> o_led counts 20 mod 8 = 4; no double counts.
6. BTN_AUTOREPEAT_EN defined, hold 20 cycles past acceptance -> press strobes at acceptance, +8, +11, +14, +17; macro undefined -> only the acceptance strobe.
